// File: rtl/csr_commit_sequencer.sv
// CSR commit sequencer: queues committed CSR writes, issues one per cycle, and orders
// exception/ertn strobes behind them. Optional perf counters under CSR_SEQ_PERF_EN.
module csr_commit_sequencer #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [13:0] commit_addr,
    input  logic [31:0] commit_data,
    output logic        commit_ready,
    input  logic        evt_valid,
    input  logic        evt_is_ertn,
    input  logic [31:0] evt_era,
    input  logic [4:0]  evt_code,
    output logic        evt_ready,
    output logic        csr_wr_en,
    output logic [13:0] csr_wr_addr,
    output logic [31:0] csr_wr_data,
    output logic        excp_flush,
    output logic        ertn_flush,
    output logic [31:0] era_out,
    output logic [4:0]  excp_code_out,
    output logic        flush_done,
    output logic        busy
`ifdef CSR_SEQ_PERF_EN
    ,
    output logic [31:0] perf_wr_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_EVENT,
        S_HOLD
    } state_t;

    typedef struct packed {
        logic [13:0] addr;
        logic [31:0] data;
    } entry_t;

    state_t        r_state;
    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [HW-1:0] r_hold_cnt;

    logic          r_cap_ertn;
    logic [31:0]   r_cap_era;
    logic [4:0]    r_cap_code;

    logic          r_csr_wr_en;
    logic [13:0]   r_csr_wr_addr;
    logic [31:0]   r_csr_wr_data;
    logic          r_excp_flush;
    logic          r_ertn_flush;
    logic [31:0]   r_era_out;
    logic [4:0]    r_code_out;
    logic          r_flush_done;

    logic          w_commit_ready;
    logic          w_evt_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_evt_acc;
    entry_t        w_head;

    // Ready is taken from registered count only, so a full queue stays closed for the
    // cycle in which it pops.
    assign w_commit_ready = (r_state == S_IDLE) && (r_count < CW'(DEPTH));
    assign w_evt_ready    = (r_state == S_IDLE);
    assign w_push         = commit_valid && w_commit_ready;
    assign w_pop          = ((r_state == S_IDLE) || (r_state == S_DRAIN)) && (r_count != '0);
    assign w_evt_acc      = evt_valid && w_evt_ready;
    assign w_head         = r_mem[r_rd_ptr];

    // NOTE: queue storage has no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{addr: commit_addr, data: commit_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_hold_cnt    <= '0;
            r_cap_ertn    <= 1'b0;
            r_cap_era     <= '0;
            r_cap_code    <= '0;
            r_csr_wr_en   <= 1'b0;
            r_csr_wr_addr <= '0;
            r_csr_wr_data <= '0;
            r_excp_flush  <= 1'b0;
            r_ertn_flush  <= 1'b0;
            r_era_out     <= '0;
            r_code_out    <= '0;
            r_flush_done  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            r_csr_wr_en <= w_pop;
            if (w_pop) begin
                r_csr_wr_addr <= w_head.addr;
                r_csr_wr_data <= w_head.data;
            end

            // Strobes and event payload are single-cycle; only the EVENT entry sets them.
            r_excp_flush <= 1'b0;
            r_ertn_flush <= 1'b0;
            r_era_out    <= '0;
            r_code_out   <= '0;
            r_flush_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_evt_acc) begin
                        r_cap_ertn <= evt_is_ertn;
                        r_cap_era  <= evt_era;
                        r_cap_code <= evt_code;
                        r_state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_count == '0) begin
                        r_state      <= S_EVENT;
                        r_excp_flush <= !r_cap_ertn;
                        r_ertn_flush <= r_cap_ertn;
                        r_era_out    <= r_cap_era;
                        r_code_out   <= r_cap_code;
                    end
                end
                S_EVENT: begin
                    r_state      <= S_HOLD;
                    r_hold_cnt   <= '0;
                    r_flush_done <= (HOLD_CYCLES == 1);
                end
                S_HOLD: begin
                    if (r_hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hold_cnt   <= r_hold_cnt + 1'b1;
                        r_flush_done <= ((r_hold_cnt + 1'b1) == HW'(HOLD_CYCLES - 1));
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CSR_SEQ_PERF_EN
    logic [31:0] r_perf_wr_cnt;
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_wr_cnt    <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (r_csr_wr_en) begin
                r_perf_wr_cnt <= r_perf_wr_cnt + 32'd1;
            end
            if (commit_valid && !w_commit_ready) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_wr_cnt    = r_perf_wr_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

    assign commit_ready  = w_commit_ready;
    assign evt_ready     = w_evt_ready;
    assign busy          = (r_state != S_IDLE) || (r_count != '0);
    assign csr_wr_en     = r_csr_wr_en;
    assign csr_wr_addr   = r_csr_wr_addr;
    assign csr_wr_data   = r_csr_wr_data;
    assign excp_flush    = r_excp_flush;
    assign ertn_flush    = r_ertn_flush;
    assign era_out       = r_era_out;
    assign excp_code_out = r_code_out;
    assign flush_done    = r_flush_done;

endmodule
